// File: rtl/pll_spi_pkg.sv
// Shared encodings for the PLL SPI master: controller/shifter states, command bytes, frame assembly.
package pll_spi_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_FRAME,
    ST_GAP,
    ST_DATA_FRAME,
    ST_FINISH,
    ST_RECOVER,
    ST_VERIFY_GAP,
    ST_VERIFY_ADDR,
    ST_VERIFY_GAP2,
    ST_VERIFY_READ
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_WRITE,
    OP_READ
  } op_e;

  typedef enum logic [1:0] {
    SH_IDLE,
    SH_LOW,
    SH_HIGH,
    SH_TAIL
  } sh_state_e;

  localparam logic [7:0] CMD_ADDR  = 8'h00;
  localparam logic [7:0] CMD_WRITE = 8'h40;
  localparam logic [7:0] CMD_READ  = 8'h80;

  function automatic logic [15:0] frame_word(input logic [7:0] cmd, input logic [7:0] payload);
    return {cmd, payload};
  endfunction

endpackage

// File: rtl/pll_spi_master_shifter.sv
// One 16-bit SPI mode-0 frame: cs_n low for 33 half-periods, MSB first, MISO sampled as SCLK rises.
// rx_o keeps the last eight received bits, i.e. the data byte of the frame.
module pll_spi_shifter
  import pll_spi_pkg::*;
#(
  parameter int unsigned SCLK_HALF = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [15:0] word_i,
  input  logic        miso_i,
  output logic        done_o,
  output logic [7:0]  rx_o,
  output logic        sclk_o,
  output logic        cs_n_o,
  output logic        mosi_o
);

  localparam int unsigned HW        = $clog2(SCLK_HALF);
  localparam int unsigned HALF_M1   = SCLK_HALF - 1;
  localparam logic [HW-1:0] HALF_LOAD = HALF_M1[HW-1:0];

  sh_state_e     state_q, state_d;
  logic [HW-1:0] half_q, half_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic          sclk_q, sclk_d;
  logic          cs_n_q, cs_n_d;
  logic          mosi_q, mosi_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SH_IDLE;
      half_q  <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    mosi_d  = mosi_q;
    done_o  = 1'b0;
    case (state_q)
      SH_IDLE: begin
        if (start_i) begin
          state_d = SH_LOW;
          cs_n_d  = 1'b0;
          mosi_d  = word_i[15];
          tx_d    = {word_i[14:0], 1'b0};
          bit_d   = 4'd15;
          half_d  = HALF_LOAD;
        end
      end
      SH_LOW: begin
        if (half_q == '0) begin
          state_d = SH_HIGH;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[6:0], miso_i};
          half_d  = HALF_LOAD;
        end else begin
          half_d = half_q - 1'b1;
        end
      end
      SH_HIGH: begin
        if (half_q == '0) begin
          sclk_d = 1'b0;
          half_d = HALF_LOAD;
          if (bit_q == 4'd0) begin
            state_d = SH_TAIL;
            mosi_d  = 1'b0;
          end else begin
            state_d = SH_LOW;
            mosi_d  = tx_q[15];
            tx_d    = {tx_q[14:0], 1'b0};
            bit_d   = bit_q - 4'd1;
          end
        end else begin
          half_d = half_q - 1'b1;
        end
      end
      SH_TAIL: begin
        if (half_q == '0) begin
          state_d = SH_IDLE;
          cs_n_d  = 1'b1;
          done_o  = 1'b1;
        end else begin
          half_d = half_q - 1'b1;
        end
      end
      default: state_d = SH_IDLE;
    endcase
    // Abort drops the bus to idle on the very next edge without finishing the bit.
    if (abort_i) begin
      state_d = SH_IDLE;
      cs_n_d  = 1'b1;
      sclk_d  = 1'b0;
      mosi_d  = 1'b0;
      done_o  = 1'b0;
    end
  end

  assign rx_o   = rx_q;
  assign sclk_o = sclk_q;
  assign cs_n_o = cs_n_q;
  assign mosi_o = mosi_q;

endmodule

// File: rtl/pll_spi_master.sv
// PLL register SPI master: set-address frame then write/read data frame per if_* command.
// Optional write readback check enabled by defining PLL_SPI_WRITE_VERIFY_EN (adds if_verify_err).
//  state          | meaning
//  ST_IDLE        | waiting for if_reset=0, latches command
//  ST_ADDR_FRAME  | address frame on the bus
//  ST_GAP         | cs_n high between frames
//  ST_DATA_FRAME  | write-data or read-data frame
//  ST_FINISH      | if_done held until if_reset=1
//  ST_RECOVER     | cs_n high after abort
//  ST_VERIFY_*    | readback gap/addr/gap/read after a write
module pll_spi_master
  import pll_spi_pkg::*;
#(
  parameter int unsigned SCLK_HALF = 8,
  parameter int unsigned CS_IDLE   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       if_reset,
  input  logic       if_read,
  input  logic       if_write,
  input  logic [7:0] if_addr,
  input  logic [7:0] if_wdata,
  output logic [7:0] if_rdata,
  output logic       if_done,
  output logic       spi_sclk,
  output logic       spi_cs_n,
  output logic       spi_mosi,
  input  logic       spi_miso
`ifdef PLL_SPI_WRITE_VERIFY_EN
  ,
  output logic       if_verify_err
`endif
);

  localparam int unsigned GW       = $clog2(CS_IDLE);
  localparam int unsigned GAP_M2   = CS_IDLE - 2;
  localparam int unsigned REC_M1   = CS_IDLE - 1;
  // The frame launch cycle also holds cs_n high, so the gap counter runs one short.
  localparam logic [GW-1:0] GAP_LOAD = GAP_M2[GW-1:0];
  localparam logic [GW-1:0] REC_LOAD = REC_M1[GW-1:0];

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rdata_q, rdata_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          launched_q, launched_d;
`ifdef PLL_SPI_WRITE_VERIFY_EN
  logic          verr_q, verr_d;
`endif

  logic        shf_start, shf_abort, shf_done;
  logic [15:0] shf_word;
  logic [7:0]  shf_rx;

  pll_spi_shifter #(.SCLK_HALF(SCLK_HALF)) u_shifter (
    .clk     (clk),
    .reset   (reset),
    .start_i (shf_start),
    .abort_i (shf_abort),
    .word_i  (shf_word),
    .miso_i  (spi_miso),
    .done_o  (shf_done),
    .rx_o    (shf_rx),
    .sclk_o  (spi_sclk),
    .cs_n_o  (spi_cs_n),
    .mosi_o  (spi_mosi)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      gap_q      <= '0;
      launched_q <= 1'b0;
`ifdef PLL_SPI_WRITE_VERIFY_EN
      verr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      gap_q      <= gap_d;
      launched_q <= launched_d;
`ifdef PLL_SPI_WRITE_VERIFY_EN
      verr_q     <= verr_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    gap_d      = gap_q;
    launched_d = launched_q;
`ifdef PLL_SPI_WRITE_VERIFY_EN
    verr_d     = verr_q;
`endif
    shf_start  = 1'b0;
    shf_abort  = 1'b0;
    shf_word   = frame_word(CMD_ADDR, addr_q);
    case (state_q)
      ST_IDLE: begin
        if (!if_reset) begin
          addr_d     = if_addr;
          wdata_d    = if_wdata;
          op_d       = if_read ? OP_READ : (if_write ? OP_WRITE : OP_NONE);
          launched_d = 1'b0;
          state_d    = ST_ADDR_FRAME;
`ifdef PLL_SPI_WRITE_VERIFY_EN
          verr_d     = 1'b0;
`endif
        end
      end
      ST_ADDR_FRAME: begin
        if (!launched_q) begin
          shf_start  = 1'b1;
          launched_d = 1'b1;
        end else if (shf_done) begin
          launched_d = 1'b0;
          if (op_q == OP_NONE) begin
            state_d = ST_FINISH;
          end else begin
            state_d = ST_GAP;
            gap_d   = GAP_LOAD;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_DATA_FRAME;
        else             gap_d   = gap_q - 1'b1;
      end
      ST_DATA_FRAME: begin
        shf_word = (op_q == OP_WRITE) ? frame_word(CMD_WRITE, wdata_q) : frame_word(CMD_READ, 8'h00);
        if (!launched_q) begin
          shf_start  = 1'b1;
          launched_d = 1'b1;
        end else if (shf_done) begin
          launched_d = 1'b0;
`ifdef PLL_SPI_WRITE_VERIFY_EN
          if (op_q == OP_WRITE) begin
            state_d = ST_VERIFY_GAP;
            gap_d   = GAP_LOAD;
          end else
`endif
          begin
            state_d = ST_FINISH;
            if (op_q == OP_READ) rdata_d = shf_rx;
          end
        end
      end
`ifdef PLL_SPI_WRITE_VERIFY_EN
      ST_VERIFY_GAP: begin
        if (gap_q == '0) state_d = ST_VERIFY_ADDR;
        else             gap_d   = gap_q - 1'b1;
      end
      ST_VERIFY_ADDR: begin
        if (!launched_q) begin
          shf_start  = 1'b1;
          launched_d = 1'b1;
        end else if (shf_done) begin
          launched_d = 1'b0;
          state_d    = ST_VERIFY_GAP2;
          gap_d      = GAP_LOAD;
        end
      end
      ST_VERIFY_GAP2: begin
        if (gap_q == '0) state_d = ST_VERIFY_READ;
        else             gap_d   = gap_q - 1'b1;
      end
      ST_VERIFY_READ: begin
        shf_word = frame_word(CMD_READ, 8'h00);
        if (!launched_q) begin
          shf_start  = 1'b1;
          launched_d = 1'b1;
        end else if (shf_done) begin
          launched_d = 1'b0;
          state_d    = ST_FINISH;
          rdata_d    = shf_rx;
          if (shf_rx != wdata_q) verr_d = 1'b1;
        end
      end
`endif
      ST_FINISH: begin
        if (if_reset) state_d = ST_IDLE;
      end
      ST_RECOVER: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // Command withdrawn mid-transaction: drop the bus, no done, no rdata update.
    if (if_reset && !(state_q inside {ST_IDLE, ST_FINISH, ST_RECOVER})) begin
      shf_start  = 1'b0;
      shf_abort  = 1'b1;
      state_d    = ST_RECOVER;
      gap_d      = REC_LOAD;
      launched_d = 1'b0;
      rdata_d    = rdata_q;
    end
  end

  assign if_rdata = rdata_q;
  assign if_done  = (state_q == ST_FINISH);
`ifdef PLL_SPI_WRITE_VERIFY_EN
  assign if_verify_err = verr_q;
`endif

endmodule

// File: tb/tb_pll_spi_master.sv
// Self-checking bench for pll_spi_master: bus monitor + slave model, frame/timing/rdata reference model.
module tb_pll_spi_master;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       if_reset = 1'b1;
  logic       if_read = 1'b0;
  logic       if_write = 1'b0;
  logic [7:0] if_addr = 8'h00;
  logic [7:0] if_wdata = 8'h00;
  logic [7:0] if_rdata;
  logic       if_done;
  logic       spi_sclk;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
`ifdef PLL_SPI_WRITE_VERIFY_EN
  logic       if_verify_err;
`endif

  int checks = 0;
  int errors = 0;

  pll_spi_master dut (
    .clk      (clk),
    .reset    (reset),
    .if_reset (if_reset),
    .if_read  (if_read),
    .if_write (if_write),
    .if_addr  (if_addr),
    .if_wdata (if_wdata),
    .if_rdata (if_rdata),
    .if_done  (if_done),
    .spi_sclk (spi_sclk),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
`ifdef PLL_SPI_WRITE_VERIFY_EN
    ,
    .if_verify_err (if_verify_err)
`endif
  );

  always #5 clk = ~clk;

  localparam int LOW_CYC  = 33 * 8;
  localparam int GAP_CYC  = 16;
  localparam int WAIT_MAX = 3000;

  // Bus monitor and slave: records every cs_n-low window, drives miso from resp_word MSB first.
  logic [15:0] fr_word[$];
  int          fr_low[$];
  int          fr_high[$];
  logic [7:0]  miso_resp = 8'h00;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;
  int          low_cnt = 0;
  int          high_cnt = 0;
  int          hold_high = 0;
  int          rise = 0;
  int          sclk_viol = 0;
  logic [15:0] cur = 16'h0;
  logic [15:0] resp_word;

  always @(negedge clk) begin
    resp_word = {8'h00, miso_resp};
    if (spi_cs_n) begin
      if (!prev_cs) begin
        fr_word.push_back(cur);
        fr_low.push_back(low_cnt);
        fr_high.push_back(hold_high);
        high_cnt = 0;
      end
      high_cnt++;
      rise = 0;
      if (spi_sclk) sclk_viol++;
    end else begin
      if (prev_cs) begin
        hold_high = high_cnt;
        low_cnt = 0;
        rise = 0;
        cur = 16'h0;
      end
      low_cnt++;
      if (spi_sclk && !prev_sclk) begin
        cur = {cur[14:0], spi_mosi};
        rise++;
      end
    end
    spi_miso = (rise < 16) ? resp_word[15 - rise] : 1'b0;
    prev_cs = spi_cs_n;
    prev_sclk = spi_sclk;
  end

  logic [7:0] exp_rdata = 8'h00;

  task automatic clear_mon();
    fr_word.delete();
    fr_low.delete();
    fr_high.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    if_reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b want 1", spi_cs_n); end
    checks++; if (spi_sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", spi_sclk); end
    checks++; if (spi_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", spi_mosi); end
    checks++; if (if_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", if_done); end
    checks++; if (if_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", if_rdata); end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (spi_cs_n !== 1'b1 || if_done !== 1'b0) begin
      errors++; $display("FAIL idle_hold: cs_n=%b done=%b want 1/0", spi_cs_n, if_done);
    end
  endtask

  // Full command scenario: reference frame list built from the command, then compared with the bus.
  task automatic test_command(input string name, input bit rd, input bit wr,
                              input logic [7:0] a, input logic [7:0] d, input logic [7:0] resp);
    logic [15:0] exp_w[$];
    int cyc;
    bit held;
`ifdef PLL_SPI_WRITE_VERIFY_EN
    bit exp_err;
    exp_err = !rd && wr && (resp != d);
`endif
    exp_w.delete();
    exp_w.push_back({8'h00, a});
    if (rd) begin
      exp_w.push_back(16'h8000);
      exp_rdata = resp;
    end else if (wr) begin
      exp_w.push_back({8'h40, d});
`ifdef PLL_SPI_WRITE_VERIFY_EN
      exp_w.push_back({8'h00, a});
      exp_w.push_back(16'h8000);
      exp_rdata = resp;
`endif
    end
    clear_mon();
    miso_resp = resp;
    @(negedge clk);
    if_read = rd; if_write = wr; if_addr = a; if_wdata = d;
    if_reset = 1'b0;
`ifdef PLL_SPI_WRITE_VERIFY_EN
    repeat (3) @(negedge clk);
    checks++; if (if_verify_err !== 1'b0) begin
      errors++; $display("FAIL %s verify_err_clear: got %b want 0", name, if_verify_err);
    end
`endif
    cyc = 0;
    while (if_done !== 1'b1 && cyc < WAIT_MAX) begin @(negedge clk); cyc++; end
    checks++; if (if_done !== 1'b1) begin errors++; $display("FAIL %s done_timeout: got %b want 1", name, if_done); end
    @(negedge clk);
    checks++; if (fr_word.size() != exp_w.size()) begin
      errors++; $display("FAIL %s frame_count: got %0d want %0d", name, fr_word.size(), exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < fr_word.size(); i++) begin
      checks++; if (fr_word[i] !== exp_w[i]) begin
        errors++; $display("FAIL %s frame_word[%0d]: got %h want %h", name, i, fr_word[i], exp_w[i]);
      end
      checks++; if (fr_low[i] != LOW_CYC) begin
        errors++; $display("FAIL %s cs_low[%0d]: got %0d want %0d", name, i, fr_low[i], LOW_CYC);
      end
      if (i > 0) begin
        checks++; if (fr_high[i] != GAP_CYC) begin
          errors++; $display("FAIL %s cs_gap[%0d]: got %0d want %0d", name, i, fr_high[i], GAP_CYC);
        end
      end
    end
    checks++; if (if_rdata !== exp_rdata) begin
      errors++; $display("FAIL %s rdata: got %h want %h", name, if_rdata, exp_rdata);
    end
`ifdef PLL_SPI_WRITE_VERIFY_EN
    checks++; if (if_verify_err !== exp_err) begin
      errors++; $display("FAIL %s verify_err: got %b want %b", name, if_verify_err, exp_err);
    end
`endif
    held = 1'b1;
    repeat (20) begin @(negedge clk); if (if_done !== 1'b1 || spi_cs_n !== 1'b1) held = 1'b0; end
    checks++; if (!held) begin errors++; $display("FAIL %s done_hold: done=%b cs_n=%b want 1/1", name, if_done, spi_cs_n); end
    if_reset = 1'b1;
    @(negedge clk);
    checks++; if (if_done !== 1'b0) begin errors++; $display("FAIL %s done_clear: got %b want 0", name, if_done); end
    checks++; if (if_rdata !== exp_rdata) begin
      errors++; $display("FAIL %s rdata_after_clear: got %h want %h", name, if_rdata, exp_rdata);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      test_command("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   8'($urandom), 8'($urandom), 8'($urandom));
    end
  endtask

  task automatic test_abort();
    int cyc, hc;
    bit done_seen;
    clear_mon();
    miso_resp = 8'h5A;
    @(negedge clk);
    if_read = 1'b1; if_write = 1'b0; if_addr = 8'h10; if_wdata = 8'h00;
    if_reset = 1'b0;
    cyc = 0;
    while (!(fr_word.size() == 1 && spi_cs_n === 1'b0 && rise == 5) && cyc < WAIT_MAX) begin
      @(negedge clk); cyc++;
    end
    checks++; if (cyc >= WAIT_MAX) begin errors++; $display("FAIL abort_reach_bit5: timed out after %0d cycles", cyc); end
    if_reset = 1'b1;
    @(negedge clk);
    checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL abort_cs_n: got %b want 1", spi_cs_n); end
    checks++; if (spi_sclk !== 1'b0) begin errors++; $display("FAIL abort_sclk: got %b want 0", spi_sclk); end
    if_read = 1'b0; if_write = 1'b1; if_addr = 8'h20; if_wdata = 8'h11;
    if_reset = 1'b0;
    hc = 1;
    done_seen = 1'b0;
    while (spi_cs_n === 1'b1 && hc < 200) begin
      @(negedge clk);
      if (if_done === 1'b1) done_seen = 1'b1;
      if (spi_cs_n === 1'b1) hc++;
    end
    checks++; if (hc < 16) begin errors++; $display("FAIL abort_recover_high: got %0d want >=16", hc); end
    checks++; if (done_seen) begin errors++; $display("FAIL abort_no_done: got 1 want 0"); end
    checks++; if (if_rdata !== exp_rdata) begin errors++; $display("FAIL abort_rdata: got %h want %h", if_rdata, exp_rdata); end
`ifdef PLL_SPI_WRITE_VERIFY_EN
    exp_rdata = miso_resp;
`endif
    cyc = 0;
    while (if_done !== 1'b1 && cyc < WAIT_MAX) begin @(negedge clk); cyc++; end
    checks++; if (if_done !== 1'b1) begin errors++; $display("FAIL abort_next_done: got %b want 1", if_done); end
    if_reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sync_reset();
    int cyc;
    clear_mon();
    @(negedge clk);
    if_read = 1'b0; if_write = 1'b1; if_addr = 8'h55; if_wdata = 8'h66;
    if_reset = 1'b0;
    cyc = 0;
    while (!(spi_cs_n === 1'b0 && rise == 3) && cyc < WAIT_MAX) begin @(negedge clk); cyc++; end
    checks++; if (cyc >= WAIT_MAX) begin errors++; $display("FAIL sreset_reach: timed out after %0d cycles", cyc); end
    reset = 1'b1;
    if_reset = 1'b1;
    @(negedge clk);
    exp_rdata = 8'h00;
    checks++; if (spi_cs_n !== 1'b1 || spi_sclk !== 1'b0 || spi_mosi !== 1'b0) begin
      errors++; $display("FAIL sreset_bus: cs_n=%b sclk=%b mosi=%b want 1/0/0", spi_cs_n, spi_sclk, spi_mosi);
    end
    checks++; if (if_done !== 1'b0 || if_rdata !== 8'h00) begin
      errors++; $display("FAIL sreset_if: done=%b rdata=%h want 0/00", if_done, if_rdata);
    end
    @(negedge clk);
    reset = 1'b0;
    test_command("after_reset_write", 1'b0, 1'b1, 8'h2B, 8'h0A, 8'h0A);
  endtask

  initial begin
    test_reset();
    test_command("write_01_09", 1'b0, 1'b1, 8'h01, 8'h09, 8'h09);
    test_command("read_02", 1'b1, 1'b0, 8'h02, 8'h00, 8'hA5);
    test_command("write_after_read", 1'b0, 1'b1, 8'h07, 8'h3C, 8'h3C);
    test_command("read_and_write", 1'b1, 1'b1, 8'h03, 8'h77, 8'hC3);
    test_command("addr_only", 1'b0, 1'b0, 8'h04, 8'h00, 8'h00);
`ifdef PLL_SPI_WRITE_VERIFY_EN
    test_command("verify_mismatch", 1'b0, 1'b1, 8'h43, 8'h01, 8'h00);
`endif
    test_random();
    test_abort();
    test_sync_reset();
    checks++; if (sclk_viol != 0) begin errors++; $display("FAIL sclk_idle: got %0d toggles with cs_n high want 0", sclk_viol); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
